// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, STATUS register and store stall.
// Define UART_PARITY_EN for 8E1 frames (even parity bit after the data bits).
module uart_tx_periph #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0004
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state, state_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    cnt4;
  logic          full, empty;
  logic          hit_tx, hit_st;
  logic          push, pop;

  logic [BW-1:0] baud_cnt;
  logic          baud_done;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tx_next;
`ifdef UART_PARITY_EN
  logic          parity;
`endif

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign hit_tx = (addr == BASE_ADDR);
  assign hit_st = (addr == BASE_ADDR + 32'd4);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  // full is registered, so a same-cycle pop never frees a slot for this push
  assign push   = wr_en && hit_tx && !full;
  assign stall  = wr_en && hit_tx && full;

  assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign tx_busy   = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        tx_next = shift[0];
        if (baud_done && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx_next = parity;
        if (baud_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered: the line lags the state by one clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      tx    <= tx_next;
      if (state == IDLE || baud_done)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + BW'(1);
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_cnt <= '0;
`ifdef UART_PARITY_EN
        parity  <= ^mem[rd_ptr];
`endif
      end else if (state == DATA && baud_done) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    cnt4 = '0;
    for (int i = 0; i < CW && i < 4; i++)
      cnt4[i] = count[i];
  end

  always_comb begin
    rdata = '0;
    if (rd_en && hit_st)
      rdata = {24'b0, cnt4, 1'b0, empty, full, tx_busy};
  end

endmodule
